or1k_spr_sys_cfg_port: RTL and testbench

//  SPR-bus slave for the group-0 system registers, sitting directly downstream of the config-SPR block.
//  - Takes its static VR/VR2/UPR/CPUCFGR/xMMUCFGR/xCCFGR/DCFGR/PCCFGR/AVR words as inputs.
//  - Serves l.mfspr/l.mtspr traffic with a registered stb/ack handshake.
//  - Hosts the only writable group-0 register here, EVBAR, and flags writes to read-only registers.

---
 rtl/or1k_spr_sys_cfg_port_pkg.sv | 34 +++
 rtl/or1k_spr_sys_dec.sv | 24 ++
 rtl/or1k_spr_sys_cfg_port.sv | 164 ++++++++++++++++
 tb/tb_or1k_spr_sys_cfg_port.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_spr_sys_cfg_port_pkg.sv
// ---------------------------------------------------------------------------
// or1k_spr_sys_cfg_port_pkg
//   Shared constants for the group-0 system-register SPR port:
//   - SPR index values of the group-0 registers served by the port
//   - EVBAR field bounds (only bits [31:13] are implemented)
//   - helper that clears the unimplemented low EVBAR bits
// ---------------------------------------------------------------------------
package or1k_spr_sys_cfg_port_pkg;

    localparam logic [10:0] OR1K_SPR_SYS_VR_INDEX       = 11'd0;
    localparam logic [10:0] OR1K_SPR_SYS_UPR_INDEX      = 11'd1;
    localparam logic [10:0] OR1K_SPR_SYS_CPUCFGR_INDEX  = 11'd2;
    localparam logic [10:0] OR1K_SPR_SYS_DMMUCFGR_INDEX = 11'd3;
    localparam logic [10:0] OR1K_SPR_SYS_IMMUCFGR_INDEX = 11'd4;
    localparam logic [10:0] OR1K_SPR_SYS_DCCFGR_INDEX   = 11'd5;
    localparam logic [10:0] OR1K_SPR_SYS_ICCFGR_INDEX   = 11'd6;
    localparam logic [10:0] OR1K_SPR_SYS_DCFGR_INDEX    = 11'd7;
    localparam logic [10:0] OR1K_SPR_SYS_PCCFGR_INDEX   = 11'd8;
    localparam logic [10:0] OR1K_SPR_SYS_VR2_INDEX      = 11'd9;
    localparam logic [10:0] OR1K_SPR_SYS_AVR_INDEX      = 11'd10;
    localparam logic [10:0] OR1K_SPR_SYS_EVBAR_INDEX    = 11'd11;

    localparam int OR1K_SPR_EVBAR_MSB = 31;
    localparam int OR1K_SPR_EVBAR_LSB = 13;
    localparam int OR1K_SPR_EVBAR_W   = OR1K_SPR_EVBAR_MSB - OR1K_SPR_EVBAR_LSB + 1;

    // Select code used for any index outside the implemented map.
    localparam logic [3:0] SYS_SEL_NONE = 4'hF;

    function automatic logic [31:0] evbar_mask(input logic [31:0] v);
        return {v[OR1K_SPR_EVBAR_MSB:OR1K_SPR_EVBAR_LSB], {OR1K_SPR_EVBAR_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/or1k_spr_sys_dec.sv
// ---------------------------------------------------------------------------
// or1k_spr_sys_dec
//   Combinational group-0 index decoder.
//   i_index : SPR index (addr[10:0])
//   o_sel   : 4-bit register select (meaningful only when o_hit=1)
//   o_hit   : index is one of the implemented registers 0..11
//   o_ro    : index is one of the always read-only registers 0..10
// ---------------------------------------------------------------------------
module or1k_spr_sys_dec
    import or1k_spr_sys_cfg_port_pkg::*;
(
    input  logic [10:0] i_index,
    output logic [3:0]  o_sel,
    output logic        o_hit,
    output logic        o_ro
);

    always_comb begin
        o_sel = i_index[3:0];
        o_hit = (i_index <= OR1K_SPR_SYS_EVBAR_INDEX);
        o_ro  = (i_index <= OR1K_SPR_SYS_AVR_INDEX);
    end

endmodule

// File: rtl/or1k_spr_sys_cfg_port.sv
// ---------------------------------------------------------------------------
// or1k_spr_sys_cfg_port
//   SPR-bus slave for the group-0 system registers. Static config words
//   arrive as inputs; EVBAR is the only register that may be written.
//   Ports:
//     cpu_clk, cpu_rst            clock, async active-high reset
//     spr_bus_addr_i/we_i/stb_i/dat_i   SPR request (stb held until ack)
//     spr_vr .. spr_avr           static config words
//     spr_bus_ack_o               one-cycle acknowledge
//     spr_bus_dat_o               read data during ack, 0 otherwise
//     spr_evbar_o                 current EVBAR value
//     spr_ro_wr_err_o             pulse with ack on a write to a read-only reg
//   Handshake: a request is taken when stb=1 and the group field is 0. The
//   access completes on the following edge if stb is still high; ack is high
//   for one cycle, then the port waits for stb to drop before the next one.
// ---------------------------------------------------------------------------
module or1k_spr_sys_cfg_port
    import or1k_spr_sys_cfg_port_pkg::*;
#(
    parameter string       FEATURE_EVBAR      = "NONE",
    parameter logic [31:0] OPTION_EVBAR_RESET = 32'h0
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [15:0] spr_bus_addr_i,
    input  logic        spr_bus_we_i,
    input  logic        spr_bus_stb_i,
    input  logic [31:0] spr_bus_dat_i,
    input  logic [31:0] spr_vr,
    input  logic [31:0] spr_vr2,
    input  logic [31:0] spr_upr,
    input  logic [31:0] spr_cpucfgr,
    input  logic [31:0] spr_dmmucfgr,
    input  logic [31:0] spr_immucfgr,
    input  logic [31:0] spr_dccfgr,
    input  logic [31:0] spr_iccfgr,
    input  logic [31:0] spr_dcfgr,
    input  logic [31:0] spr_pccfgr,
    input  logic [31:0] spr_avr,
    output logic        spr_bus_ack_o,
    output logic [31:0] spr_bus_dat_o,
    output logic [31:0] spr_evbar_o,
    output logic        spr_ro_wr_err_o
);

    localparam bit          EVBAR_EN  = (FEATURE_EVBAR != "NONE");
    // Without EVBAR the register reads as 0 and the output is held at 0.
    localparam logic [31:0] EVBAR_RST = EVBAR_EN ? evbar_mask(OPTION_EVBAR_RESET) : 32'h0;
    localparam logic [3:0]  SEL_EVBAR = OR1K_SPR_SYS_EVBAR_INDEX[3:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    state_e                      r_state;
    logic [3:0]                  r_sel;
    logic                        r_we;
    logic                        r_ro;
    logic [OR1K_SPR_EVBAR_W-1:0] r_wdat;
    logic                        r_ack;
    logic [31:0]                 r_dat;
    logic                        r_err;
    logic [31:0]                 r_evbar;

    logic [3:0]  w_sel;
    logic        w_hit;
    logic        w_ro;
    logic        w_accept;
    logic [31:0] w_rdata;
    logic        w_evbar_wr;
    logic        w_ro_err;

    or1k_spr_sys_dec u_dec (
        .i_index (spr_bus_addr_i[10:0]),
        .o_sel   (w_sel),
        .o_hit   (w_hit),
        .o_ro    (w_ro)
    );

    assign w_accept = spr_bus_stb_i && (spr_bus_addr_i[15:11] == 5'd0);

    always_comb begin
        w_rdata = 32'h0;
        case (r_sel)
            OR1K_SPR_SYS_VR_INDEX[3:0]:       w_rdata = spr_vr;
            OR1K_SPR_SYS_UPR_INDEX[3:0]:      w_rdata = spr_upr;
            OR1K_SPR_SYS_CPUCFGR_INDEX[3:0]:  w_rdata = spr_cpucfgr;
            OR1K_SPR_SYS_DMMUCFGR_INDEX[3:0]: w_rdata = spr_dmmucfgr;
            OR1K_SPR_SYS_IMMUCFGR_INDEX[3:0]: w_rdata = spr_immucfgr;
            OR1K_SPR_SYS_DCCFGR_INDEX[3:0]:   w_rdata = spr_dccfgr;
            OR1K_SPR_SYS_ICCFGR_INDEX[3:0]:   w_rdata = spr_iccfgr;
            OR1K_SPR_SYS_DCFGR_INDEX[3:0]:    w_rdata = spr_dcfgr;
            OR1K_SPR_SYS_PCCFGR_INDEX[3:0]:   w_rdata = spr_pccfgr;
            OR1K_SPR_SYS_VR2_INDEX[3:0]:      w_rdata = spr_vr2;
            OR1K_SPR_SYS_AVR_INDEX[3:0]:      w_rdata = spr_avr;
            SEL_EVBAR:                        w_rdata = r_evbar;
            default:                          w_rdata = 32'h0;
        endcase
    end

    assign w_evbar_wr = r_we && EVBAR_EN && (r_sel == SEL_EVBAR);
    // EVBAR counts as read-only when the feature is absent.
    assign w_ro_err   = r_we && (r_ro || (!EVBAR_EN && (r_sel == SEL_EVBAR)));

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state <= ST_IDLE;
            r_sel   <= SYS_SEL_NONE;
            r_we    <= 1'b0;
            r_ro    <= 1'b0;
            r_wdat  <= '0;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0;
            r_err   <= 1'b0;
            r_evbar <= EVBAR_RST;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= w_hit ? w_sel : SYS_SEL_NONE;
                        r_ro    <= w_ro;
                        r_we    <= spr_bus_we_i;
                        r_wdat  <= spr_bus_dat_i[OR1K_SPR_EVBAR_MSB:OR1K_SPR_EVBAR_LSB];
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!spr_bus_stb_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dat   <= w_rdata;
                        r_ack   <= 1'b1;
                        r_err   <= w_ro_err;
                        if (w_evbar_wr)
                            r_evbar <= {r_wdat, {OR1K_SPR_EVBAR_LSB{1'b0}}};
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_dat   <= 32'h0;
                    r_err   <= 1'b0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // A strobe still held from the served request must not
                    // start a second access.
                    if (!spr_bus_stb_i)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spr_bus_ack_o   = r_ack;
    assign spr_bus_dat_o   = r_dat;
    assign spr_evbar_o     = r_evbar;
    assign spr_ro_wr_err_o = r_err;

endmodule

// File: tb/tb_or1k_spr_sys_cfg_port.sv
module tb_or1k_spr_sys_cfg_port;

  localparam logic [31:0] RST_VAL = 32'h1234_5678;
  localparam logic [31:0] RST_EXP = 32'h1234_4000;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        we;
  logic        stb;
  logic [31:0] wdat;
  logic [31:0] cfg [11];

  logic        ack,   n_ack;
  logic [31:0] dat,   n_dat;
  logic [31:0] evbar, n_evbar;
  logic        err,   n_err;

  int tests;
  int fails;

  // reference state: EVBAR of the enabled instance (the NONE one is always 0)
  logic [31:0] m_evbar;

  // config word array index == SPR index of that register
  or1k_spr_sys_cfg_port #(
    .FEATURE_EVBAR      ("ENABLED"),
    .OPTION_EVBAR_RESET (RST_VAL)
  ) dut (
    .cpu_clk         (clk),
    .cpu_rst         (rst),
    .spr_bus_addr_i  (addr),
    .spr_bus_we_i    (we),
    .spr_bus_stb_i   (stb),
    .spr_bus_dat_i   (wdat),
    .spr_vr          (cfg[0]),
    .spr_vr2         (cfg[9]),
    .spr_upr         (cfg[1]),
    .spr_cpucfgr     (cfg[2]),
    .spr_dmmucfgr    (cfg[3]),
    .spr_immucfgr    (cfg[4]),
    .spr_dccfgr      (cfg[5]),
    .spr_iccfgr      (cfg[6]),
    .spr_dcfgr       (cfg[7]),
    .spr_pccfgr      (cfg[8]),
    .spr_avr         (cfg[10]),
    .spr_bus_ack_o   (ack),
    .spr_bus_dat_o   (dat),
    .spr_evbar_o     (evbar),
    .spr_ro_wr_err_o (err)
  );

  or1k_spr_sys_cfg_port #(
    .FEATURE_EVBAR      ("NONE"),
    .OPTION_EVBAR_RESET (32'h0)
  ) dut_none (
    .cpu_clk         (clk),
    .cpu_rst         (rst),
    .spr_bus_addr_i  (addr),
    .spr_bus_we_i    (we),
    .spr_bus_stb_i   (stb),
    .spr_bus_dat_i   (wdat),
    .spr_vr          (cfg[0]),
    .spr_vr2         (cfg[9]),
    .spr_upr         (cfg[1]),
    .spr_cpucfgr     (cfg[2]),
    .spr_dmmucfgr    (cfg[3]),
    .spr_immucfgr    (cfg[4]),
    .spr_dccfgr      (cfg[5]),
    .spr_iccfgr      (cfg[6]),
    .spr_dcfgr       (cfg[7]),
    .spr_pccfgr      (cfg[8]),
    .spr_avr         (cfg[10]),
    .spr_bus_ack_o   (n_ack),
    .spr_bus_dat_o   (n_dat),
    .spr_evbar_o     (n_evbar),
    .spr_ro_wr_err_o (n_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [10:0] idx, input bit evbar_en);
    if (idx <= 11'd10) return cfg[idx];
    if (idx == 11'd11) return evbar_en ? m_evbar : 32'h0;
    return 32'h0;
  endfunction

  task automatic scramble_cfg();
    for (int i = 0; i < 11; i++) cfg[i] = $urandom;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_ack"}, {31'b0, ack}, 32'd0);
    chk({tag, "_dat"}, dat, 32'h0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_n_ack"}, {31'b0, n_ack}, 32'd0);
  endtask

  // One SPR request. hold_extra: cycles stb stays high after the ack cycle.
  // abort_req: stb drops in the access cycle. scramble: config inputs change
  // right after the access edge.
  task automatic xact(input logic [15:0] a, input logic w, input logic [31:0] d,
                      input int hold_extra, input bit abort_req, input bit scramble);
    logic [10:0] idx;
    bit          grp_ok;
    logic [31:0] e_dat, e_ndat;
    logic        e_err, e_nerr;
    idx    = a[10:0];
    grp_ok = (a[15:11] == 5'd0);
    e_dat  = model_read(idx, 1'b1);
    e_ndat = model_read(idx, 1'b0);
    e_err  = w && (idx <= 11'd10);
    e_nerr = w && (idx <= 11'd11);

    @(posedge clk); #1;
    addr = a; we = w; wdat = d; stb = 1'b1;
    @(posedge clk); #1;
    idle_checks("pre_ack");

    if (!grp_ok) begin
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        idle_checks("other_group");
      end
      stb = 1'b0;
      @(posedge clk); #1;
      return;
    end

    if (abort_req) begin
      stb = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        idle_checks("abort");
        chk("abort_evbar", evbar, m_evbar);
      end
      return;
    end

    @(posedge clk); #1;
    if (w && idx == 11'd11) m_evbar = d & 32'hFFFF_E000;
    if (scramble) scramble_cfg();
    chk("ack", {31'b0, ack}, 32'd1);
    chk("ack_dat", dat, e_dat);
    chk("ack_err", {31'b0, err}, {31'b0, e_err});
    chk("ack_evbar", evbar, m_evbar);
    chk("n_ack", {31'b0, n_ack}, 32'd1);
    chk("n_ack_dat", n_dat, e_ndat);
    chk("n_ack_err", {31'b0, n_err}, {31'b0, e_nerr});
    chk("n_evbar", n_evbar, 32'h0);

    for (int c = 0; c < hold_extra; c++) begin
      @(posedge clk); #1;
      idle_checks("held_stb");
    end
    stb = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      idle_checks("post_ack");
      chk("post_evbar", evbar, m_evbar);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [31:0] rd;
    int          kind;
    tests = 0; fails = 0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 16'h0; wdat = 32'h0;
    scramble_cfg();
    m_evbar = RST_EXP;

    repeat (2) @(posedge clk);
    #1;
    idle_checks("reset");
    chk("reset_evbar", evbar, RST_EXP);
    chk("reset_n_evbar", n_evbar, 32'h0);
    rst = 1'b0;

    // read VR
    cfg[0] = 32'h1000_0040;
    xact(16'h0000, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    // EVBAR write then read-back
    xact(16'h000B, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    chk("evbar_written", evbar, 32'hDEAD_A000);
    xact(16'h000B, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    // write to read-only CPUCFGR, then read it back unchanged
    xact(16'h0002, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    xact(16'h0002, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    // other group and unimplemented index
    xact(16'h0801, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    xact(16'h07FF, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    xact(16'h07FF, 1'b1, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    // aborted EVBAR write, then read-back of the old value
    xact(16'h000B, 1'b1, 32'h1111_1111, 0, 1'b1, 1'b0);
    xact(16'h000B, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    // stb held for six cycles in total: one ack only
    xact(16'h0005, 1'b0, 32'h0, 4, 1'b0, 1'b0);
    // inputs change after the access edge
    xact(16'h000A, 1'b0, 32'h0, 0, 1'b0, 1'b1);

    // reset during the access cycle of an EVBAR write
    @(posedge clk); #1;
    addr = 16'h000B; we = 1'b1; wdat = 32'hCAFE_F00D; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", {31'b0, ack}, 32'd0);
    chk("rst_mid_evbar", evbar, RST_EXP);
    @(posedge clk); #1;
    chk("rst_mid_ack2", {31'b0, ack}, 32'd0);
    rst = 1'b0; stb = 1'b0;
    m_evbar = RST_EXP;
    xact(16'h000B, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    xact(16'h0009, 1'b0, 32'h0, 0, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      scramble_cfg();
      kind = $urandom_range(0, 9);
      if (kind == 0)
        ra = {5'($urandom_range(1, 31)), 11'($urandom_range(0, 2047))};
      else if (kind == 1)
        ra = {5'd0, 11'($urandom_range(12, 2047))};
      else
        ra = {5'd0, 11'($urandom_range(0, 11))};
      rd = $urandom;
      xact(ra, 1'($urandom_range(0, 1)), rd, $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // time limit
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
